// File: rtl/serial_addsub.sv
// serial_addsub: digit-serial two's-complement adder/subtractor.
// Processes DIGIT_W bits per clock, LSB digit first, in frames of FRAME_LEN digits.
//
// Ports:
//   clk       rising-edge clock
//   rst_b     asynchronous active-low reset
//   start     first digit of a frame (qualified by in_valid)
//   mode      sampled with start: 0 = x+y, 1 = x-y
//   in_valid  x/y digit valid this cycle
//   x, y      operand digits
//   s_valid   result digit valid (one cycle after the accepted digit)
//   s         result digit (holds when no digit is accepted)
//   done      pulse with the last result digit of a frame
//   carry_out carry out of the word MSB (sub: 1 = no borrow)
//   ovf       signed overflow of the completed frame
//   busy      frame in progress
module serial_addsub #(
  parameter int DIGIT_W   = 1,
  parameter int FRAME_LEN = 8
) (
  input  logic               clk,
  input  logic               rst_b,
  input  logic               start,
  input  logic               mode,
  input  logic               in_valid,
  input  logic [DIGIT_W-1:0] x,
  input  logic [DIGIT_W-1:0] y,
  output logic               s_valid,
  output logic [DIGIT_W-1:0] s,
  output logic               done,
  output logic               carry_out,
  output logic               ovf,
  output logic               busy
);

  localparam int CW = $clog2(FRAME_LEN);
  localparam logic [CW-1:0] LAST = CW'(FRAME_LEN - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t state_q;
  state_t state_d;

  logic          carry_q;
  logic          mode_q;
  logic [CW-1:0] cnt_q;

  logic               s_valid_q;
  logic [DIGIT_W-1:0] s_q;
  logic               done_q;
  logic               cout_q;
  logic               ovf_q;

  logic               sof;
  logic               accept;
  logic               frm_mode;
  logic               cin;
  logic [CW-1:0]      cnt_cur;
  logic [DIGIT_W-1:0] yy;
  logic [DIGIT_W:0]   sum_w;
  logic [DIGIT_W-1:0] sum;
  logic               c_out;
  logic               c_msb;
  logic               is_last;

  // A start digit always opens a new frame, even mid-frame (abort).
  assign sof    = start & in_valid;
  assign accept = sof | (in_valid & (state_q == RUN));

  assign frm_mode = sof ? mode : mode_q;
  assign cin      = sof ? mode : carry_q;
  assign cnt_cur  = sof ? '0 : cnt_q;

  assign yy    = frm_mode ? ~y : y;
  assign sum_w = {1'b0, x} + {1'b0, yy}
               + {{DIGIT_W{1'b0}}, cin};
  assign sum   = sum_w[DIGIT_W-1:0];
  assign c_out = sum_w[DIGIT_W];

  // Carry into the digit MSB recovered from the MSB sum bit;
  // reduces to cin when DIGIT_W == 1.
  assign c_msb = sum[DIGIT_W-1]
               ^ x[DIGIT_W-1]
               ^ yy[DIGIT_W-1];

  assign is_last = accept & (cnt_cur == LAST);

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (sof)     state_d = RUN;
      RUN:  if (is_last) state_d = IDLE;
      default:           state_d = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q == RUN);
    s_valid   = s_valid_q;
    s         = s_q;
    done      = done_q;
    carry_out = cout_q;
    ovf       = ovf_q;
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      carry_q   <= 1'b0;
      mode_q    <= 1'b0;
      cnt_q     <= '0;
      s_valid_q <= 1'b0;
      s_q       <= '0;
      done_q    <= 1'b0;
      cout_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      s_valid_q <= accept;
      done_q    <= is_last;
      if (sof) begin
        mode_q <= mode;
      end
      if (accept) begin
        s_q     <= sum;
        carry_q <= c_out;
        cnt_q   <= is_last ? '0 : cnt_cur + CW'(1);
      end
      if (is_last) begin
        cout_q <= c_out;
        ovf_q  <= c_msb ^ c_out;
      end
    end
  end

endmodule

// File: tb/tb_serial_addsub.sv
// tb_serial_addsub: table, hand sequences and random frames
// for two serial_addsub configurations (1x8 and 4x2 digits).
module tb_serial_addsub;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_b;

  logic       start1, mode1, iv1;
  logic [0:0] x1, y1, s1;
  logic       sv1, done1, co1, ovf1, busy1;

  logic       start2, mode2, iv2;
  logic [3:0] x2, y2, s2;
  logic       sv2, done2, co2, ovf2, busy2;

  serial_addsub #(.DIGIT_W(1), .FRAME_LEN(8)) u_d1 (
    .clk(clk), .rst_b(rst_b), .start(start1), .mode(mode1),
    .in_valid(iv1), .x(x1), .y(y1), .s_valid(sv1), .s(s1),
    .done(done1), .carry_out(co1), .ovf(ovf1), .busy(busy1)
  );

  serial_addsub #(.DIGIT_W(4), .FRAME_LEN(2)) u_d2 (
    .clk(clk), .rst_b(rst_b), .start(start2), .mode(mode2),
    .in_valid(iv2), .x(x2), .y(y2), .s_valid(sv2), .s(s2),
    .done(done2), .carry_out(co2), .ovf(ovf2), .busy(busy2)
  );

  typedef struct {
    logic [7:0] w;
    logic       c;
    logic       v;
  } res_t;

  typedef struct {
    int         cfg;
    logic [7:0] a;
    logic [7:0] b;
    logic       m;
    logic [7:0] es;
    logic       ec;
    logic       ev;
  } vec_t;

  int vectors = 0;
  int miscompares = 0;

  res_t q1[$];
  res_t q2[$];
  logic [7:0] acc1 = '0;
  logic [7:0] acc2 = '0;
  int done_cnt1 = 0;
  int run1 = 0;
  int maxrun1 = 0;

  // Reassemble result words from the digit streams.
  always @(negedge clk) begin
    res_t r;
    if (sv1) begin
      acc1 = {s1, acc1[7:1]};
      run1++;
    end else begin
      run1 = 0;
    end
    if (run1 > maxrun1) maxrun1 = run1;
    if (done1) begin
      r.w = acc1; r.c = co1; r.v = ovf1;
      q1.push_back(r);
      done_cnt1++;
    end
    if (sv2) acc2 = {s2, acc2[7:4]};
    if (done2) begin
      r.w = acc2; r.c = co2; r.v = ovf2;
      q2.push_back(r);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Word-level reference: plain integer arithmetic on 8-bit words.
  function automatic res_t model(input logic [7:0] a,
                                 input logic [7:0] b,
                                 input logic m);
    res_t r;
    int ua, ub, sa, sb, sum, sr;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    sum = m ? ua + (255 - ub) + 1 : ua + ub;
    sr  = m ? sa - sb : sa + sb;
    r.w = 8'(sum);
    r.c = (sum >= 256);
    r.v = (sr > 127) || (sr < -128);
    return r;
  endfunction

  task automatic send1(input logic [7:0] a, input logic [7:0] b,
                       input logic m, input int ndig,
                       input int stall_at, input int stall_len);
    for (int i = 0; i < ndig; i++) begin
      start1 = (i == 0);
      mode1  = (i == 0) ? m : ~m;
      iv1    = 1'b1;
      x1     = a[i];
      y1     = b[i];
      @(posedge clk); #1;
      if (i == stall_at) begin
        start1 = 1'b0;
        iv1    = 1'b0;
        x1     = 1'($urandom);
        y1     = 1'($urandom);
        repeat (stall_len) begin
          @(posedge clk); #1;
        end
      end
    end
    start1 = 1'b0;
    iv1    = 1'b0;
  endtask

  task automatic send2(input logic [7:0] a, input logic [7:0] b,
                       input logic m, input int stall_at,
                       input int stall_len);
    for (int i = 0; i < 2; i++) begin
      start2 = (i == 0);
      mode2  = (i == 0) ? m : ~m;
      iv2    = 1'b1;
      x2     = a[4*i +: 4];
      y2     = b[4*i +: 4];
      @(posedge clk); #1;
      if (i == stall_at) begin
        start2 = 1'b0;
        iv2    = 1'b0;
        x2     = 4'($urandom);
        y2     = 4'($urandom);
        repeat (stall_len) begin
          @(posedge clk); #1;
        end
      end
    end
    start2 = 1'b0;
    iv2    = 1'b0;
  endtask

  task automatic get_res(input int cfg, input string nm,
                         input logic [7:0] es, input logic ec,
                         input logic ev);
    res_t r;
    int k;
    k = 0;
    while (((cfg == 1) ? q1.size() : q2.size()) == 0 && k < 50) begin
      @(negedge clk); #1;
      k++;
    end
    if (((cfg == 1) ? q1.size() : q2.size()) == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL %s: got no done, expected done", nm);
    end else begin
      if (cfg == 1) r = q1.pop_front();
      else          r = q2.pop_front();
      chk({nm, ".s"},   32'(r.w), 32'(es));
      chk({nm, ".c"},   32'(r.c), 32'(ec));
      chk({nm, ".ovf"}, 32'(r.v), 32'(ev));
    end
  endtask

  initial begin
    vec_t tbl[9];
    res_t e;
    logic [7:0] a, b;
    logic m;
    int dc, sa, sl;

    tbl[0] = '{1, 8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b0};
    tbl[1] = '{1, 8'h10, 8'h01, 1'b1, 8'h0F, 1'b1, 1'b0};
    tbl[2] = '{1, 8'h00, 8'h01, 1'b1, 8'hFF, 1'b0, 1'b0};
    tbl[3] = '{1, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    tbl[4] = '{1, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    tbl[5] = '{1, 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1};
    tbl[6] = '{1, 8'h05, 8'h05, 1'b1, 8'h00, 1'b1, 1'b0};
    tbl[7] = '{2, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    tbl[8] = '{2, 8'h70, 8'h10, 1'b0, 8'h80, 1'b0, 1'b1};

    rst_b = 1'b0;
    start1 = 0; mode1 = 0; iv1 = 0; x1 = 0; y1 = 0;
    start2 = 0; mode2 = 0; iv2 = 0; x2 = 0; y2 = 0;
    #7;
    chk("rst.sv1",   32'(sv1),   0);
    chk("rst.s1",    32'(s1),    0);
    chk("rst.done1", 32'(done1), 0);
    chk("rst.co1",   32'(co1),   0);
    chk("rst.ovf1",  32'(ovf1),  0);
    chk("rst.busy1", 32'(busy1), 0);
    chk("rst.sv2",   32'(sv2),   0);
    chk("rst.s2",    32'(s2),    0);
    chk("rst.done2", 32'(done2), 0);
    chk("rst.co2",   32'(co2),   0);
    chk("rst.ovf2",  32'(ovf2),  0);
    chk("rst.busy2", 32'(busy2), 0);
    @(posedge clk); #2;
    rst_b = 1'b1;
    @(posedge clk); #1;

    // First frame digit by digit: latency, done and busy timing.
    a = 8'h35; b = 8'h4A;
    chk("lat.pre_sv", 32'(sv1), 0);
    for (int i = 0; i < 8; i++) begin
      start1 = (i == 0); mode1 = 1'b0; iv1 = 1'b1;
      x1 = a[i]; y1 = b[i];
      @(posedge clk); #1;
      chk($sformatf("lat.sv[%0d]", i),   32'(sv1),   1);
      chk($sformatf("lat.done[%0d]", i), 32'(done1), 32'(i == 7));
      chk($sformatf("lat.busy[%0d]", i), 32'(busy1), 32'(i != 7));
    end
    start1 = 1'b0; iv1 = 1'b0;
    get_res(1, "lat", 8'h7F, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk("lat.post_sv", 32'(sv1), 0);

    for (int n = 0; n < 9; n++) begin
      if (tbl[n].cfg == 1)
        send1(tbl[n].a, tbl[n].b, tbl[n].m, 8, -1, 0);
      else
        send2(tbl[n].a, tbl[n].b, tbl[n].m, -1, 0);
      get_res(tbl[n].cfg, $sformatf("tbl[%0d]", n),
              tbl[n].es, tbl[n].ec, tbl[n].ev);
      repeat (2) @(posedge clk);
      #1;
    end

    // Back-to-back frames with no bubble.
    maxrun1 = 0;
    send1(8'h7F, 8'h01, 1'b0, 8, -1, 0);
    send1(8'h80, 8'h80, 1'b0, 8, -1, 0);
    get_res(1, "b2b0", 8'h80, 1'b0, 1'b1);
    get_res(1, "b2b1", 8'h00, 1'b1, 1'b1);
    chk("b2b.sv_run", 32'(maxrun1), 16);

    // Stall for 3 cycles after the third digit.
    dc = done_cnt1;
    send1(8'h35, 8'h4A, 1'b0, 8, 2, 3);
    get_res(1, "stall", 8'h7F, 1'b0, 1'b0);
    chk("stall.dones", 32'(done_cnt1 - dc), 1);

    // Abort a partial frame (carry reg left at 1) with a new start.
    repeat (2) @(posedge clk);
    #1;
    dc = done_cnt1;
    send1(8'hFF, 8'hFF, 1'b0, 5, -1, 0);
    send1(8'h35, 8'h4A, 1'b0, 8, 2, 3);
    get_res(1, "abort", 8'h7F, 1'b0, 1'b0);
    chk("abort.dones", 32'(done_cnt1 - dc), 1);

    // Reset in the middle of a frame, after a frame set carry/ovf.
    send1(8'h80, 8'h80, 1'b0, 8, -1, 0);
    get_res(1, "prerst", 8'h00, 1'b1, 1'b1);
    @(posedge clk); #1;
    send1(8'hFF, 8'hFF, 1'b0, 4, -1, 0);
    #2;
    rst_b = 1'b0;
    #1;
    chk("mrst.sv1",   32'(sv1),   0);
    chk("mrst.s1",    32'(s1),    0);
    chk("mrst.done1", 32'(done1), 0);
    chk("mrst.co1",   32'(co1),   0);
    chk("mrst.ovf1",  32'(ovf1),  0);
    chk("mrst.busy1", 32'(busy1), 0);
    @(negedge clk);
    rst_b = 1'b1;
    @(posedge clk); #1;
    send1(8'h01, 8'h01, 1'b0, 8, -1, 0);
    get_res(1, "postrst", 8'h02, 1'b0, 1'b0);

    for (int n = 0; n < 150; n++) begin
      a = 8'($urandom); b = 8'($urandom); m = 1'($urandom);
      sa = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : -1;
      sl = int'($urandom_range(1, 3));
      send1(a, b, m, 8, sa, sl);
      e = model(a, b, m);
      get_res(1, $sformatf("rnd1[%0d]", n), e.w, e.c, e.v);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    for (int n = 0; n < 60; n++) begin
      a = 8'($urandom); b = 8'($urandom); m = 1'($urandom);
      sa = ($urandom_range(0, 2) == 0) ? 0 : -1;
      sl = int'($urandom_range(1, 3));
      send2(a, b, m, sa, sl);
      e = model(a, b, m);
      get_res(2, $sformatf("rnd2[%0d]", n), e.w, e.c, e.v);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
